// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and the default baud divisor.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  // 100 MHz / 115200 baud
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Byte push handshake between the core's OUT path and the buffered UART transmitter.
interface uart_tx_buffered_if;

  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with combinational read port; count has one extra bit to tell full from empty.
module sync_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  push,
  input  logic [WIDTH-1:0]      din,
  input  logic                  pop,
  output logic [WIDTH-1:0]      dout,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DepthCnt = (DEPTH_LOG2 + 1)'(Depth);

  logic [WIDTH-1:0]      mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wr_q, rd_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  do_push, do_pop;

  // A full FIFO refuses a push even when a pop happens on the same edge.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (!do_push && do_pop) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_q] <= din;
  end

  assign dout  = mem_q[rd_q];
  assign count = count_q;
  assign full  = (count_q == DepthCnt);
  assign empty = (count_q == '0);

endmodule

// File: rtl/uart_tx_buffered.sv
// Byte FIFO in front of an 8N1 UART serializer so the core can issue OUT without waiting a frame.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT    = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH_LOG2 = 4
) (
  input  logic                CLK,
  input  logic                RST,
  uart_tx_buffered_if.slave   in_if,
  output logic                UART_TX,
  output logic                busy
);

  localparam int unsigned TimerW = $clog2(CLKS_PER_BIT);
  localparam logic [TimerW-1:0] TimerMax = TimerW'(CLKS_PER_BIT - 1);

  logic [7:0]               fifo_dout;
  logic [FIFO_DEPTH_LOG2:0] fifo_count;
  logic                     fifo_full, fifo_empty;
  logic                     push, pop;

  tx_state_t         state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;

  assign in_if.in_ready = !RST && !fifo_full;
  assign push           = in_if.in_valid && in_if.in_ready;
  assign pop            = (state_q == IDLE) && !fifo_empty;

  sync_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push),
    .din   (in_if.in_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (pop) begin
          shift_d = fifo_dout;
          timer_d = '0;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (timer_q == TimerMax) begin
          timer_d = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DATA: begin
        if (timer_q == TimerMax) begin
          timer_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            // Shift right so the next bit to send is always at shift_q[1] -> shift_q[0].
            bit_d   = bit_q + 1'b1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      STOP: begin
        if (timer_q == TimerMax) begin
          timer_d = '0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign UART_TX = tx_q;
  assign busy    = (fifo_count != '0) || (state_q != IDLE);

endmodule
